// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: default memory map, NOP encoding,
// the F/D pipeline register payload and the fetch-range fault helper.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 4096;
  localparam int          DEF_IM_AW    = 12;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } fd_t;

  // Misaligned or outside [base, limit] is a fetch fault; limit is the last legal word address.
  function automatic logic pc_fault(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset beats flush, flush beats stall, stall beats load.
// A flush inserts a bubble that still carries the F-stage PC.
module fetch_stage_fd_reg
  import fetch_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic stall,
  input  fd_t  f_entry,
  output fd_t  d_entry
);

  fd_t d_r;

  // Priority-ordered update of the D-stage contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_r.pc    <= 32'h0000_0000;
      d_r.instr <= NOP;
      d_r.valid <= 1'b0;
      d_r.fault <= 1'b0;
    end else if (flush) begin
      d_r.pc    <= f_entry.pc;
      d_r.instr <= NOP;
      d_r.valid <= 1'b0;
      d_r.fault <= 1'b0;
    end else if (stall) begin
      d_r <= d_r;
    end else begin
      d_r <= f_entry;
    end
  end

  assign d_entry = d_r;

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, instruction-ROM addressing with fault tagging,
// F/D pipeline register and fetch/stall performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET,
  parameter int          IM_WORDS = DEF_IM_WORDS,
  parameter int          IM_AW    = DEF_IM_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_next,
  input  logic             stall,
  input  logic             fd_flush,
  input  logic [31:0]      imem_rdata,
  output logic [IM_AW-1:0] imem_addr,
  output logic [31:0]      F_pc,
  output logic [31:0]      F_instr,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_instr,
  output logic             D_valid,
  output logic             D_fault,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt
);

  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] pc_r;
  logic [31:0] pc_off_s;
  logic        f_fault_s;
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;
  fd_t         f_entry_s;
  fd_t         d_entry_s;

  // The ROM is addressed even on a fault; truncation wraps out-of-range PCs.
  assign pc_off_s  = pc_r - PC_RESET;
  assign imem_addr = IM_AW'(pc_off_s >> 2);
  assign f_fault_s = pc_fault(pc_r, PC_RESET, PC_LIMIT);

  // Faulting fetches present a NOP instead of the discarded ROM word.
  always_comb begin
    F_instr = NOP;
    if (f_fault_s) begin
      F_instr = NOP;
    end else begin
      F_instr = imem_rdata;
    end
  end

  // PC register: hold on stall, otherwise take pc_next untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pc_next;
    end
  end

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_r <= 32'h0000_0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      if (!stall && !fd_flush && !f_fault_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (stall) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign f_entry_s.pc    = pc_r;
  assign f_entry_s.instr = F_instr;
  assign f_entry_s.valid = 1'b1;
  assign f_entry_s.fault = f_fault_s;

  fetch_stage_fd_reg u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .flush   (fd_flush),
    .stall   (stall),
    .f_entry (f_entry_s),
    .d_entry (d_entry_s)
  );

  assign F_pc      = pc_r;
  assign D_pc      = d_entry_s.pc;
  assign D_instr   = d_entry_s.instr;
  assign D_valid   = d_entry_s.valid;
  assign D_fault   = d_entry_s.fault;
  assign fetch_cnt = fetch_cnt_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts each edge's
// outcome, pushes it to a queue, and the entry is popped and compared after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        stall;
  logic        fd_flush;
  logic [31:0] imem_rdata;
  logic [11:0] imem_addr;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        D_fault;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        d_fault;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_fpc   = 32'h0;
  logic [31:0] m_dpc   = 32'h0;
  logic [31:0] m_dinstr = 32'h0;
  logic        m_dvalid = 1'b0;
  logic        m_dfault = 1'b0;
  logic [31:0] m_fcnt  = 32'h0;
  logic [31:0] m_scnt  = 32'h0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc_next    (pc_next),
    .stall      (stall),
    .fd_flush   (fd_flush),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .F_pc       (F_pc),
    .F_instr    (F_instr),
    .D_pc       (D_pc),
    .D_instr    (D_instr),
    .D_valid    (D_valid),
    .D_fault    (D_fault),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {8'hA5, ~a, a};
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  function automatic logic m_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - 32'h0000_3000) >> 2;
    return m_fault(pc) ? 32'h0 : rom_word(off[11:0]);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] nxt);
    exp_t e;
    logic [31:0] cur_instr;
    logic        cur_fault;
    reset    = r;
    stall    = s;
    fd_flush = f;
    pc_next  = nxt;
    cur_fault = m_fault(m_fpc);
    cur_instr = m_instr(m_fpc);
    if (r) begin
      m_fpc = 32'h3000; m_dpc = 32'h0; m_dinstr = 32'h0;
      m_dvalid = 1'b0; m_dfault = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
    end else begin
      if (s) m_scnt = m_scnt + 32'd1;
      if (f) begin
        m_dpc = m_fpc; m_dinstr = 32'h0; m_dvalid = 1'b0; m_dfault = 1'b0;
      end else if (!s) begin
        m_dpc = m_fpc; m_dinstr = cur_instr; m_dvalid = 1'b1; m_dfault = cur_fault;
        if (!cur_fault) m_fcnt = m_fcnt + 32'd1;
      end
      if (!s) m_fpc = nxt;
    end
    e.f_pc = m_fpc; e.f_instr = m_instr(m_fpc); e.d_pc = m_dpc; e.d_instr = m_dinstr;
    e.d_valid = m_dvalid; e.d_fault = m_dfault; e.fcnt = m_fcnt; e.scnt = m_scnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("F_pc", F_pc, e.f_pc);
    check_val("F_instr", F_instr, e.f_instr);
    check_val("D_pc", D_pc, e.d_pc);
    check_val("D_instr", D_instr, e.d_instr);
    check_val("D_valid", {31'h0, D_valid}, {31'h0, e.d_valid});
    check_val("D_fault", {31'h0, D_fault}, {31'h0, e.d_fault});
    check_val("fetch_cnt", fetch_cnt, e.fcnt);
    check_val("stall_cnt", stall_cnt, e.scnt);
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; fd_flush = 1'b0; pc_next = 32'h0;

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_val("rst_fpc", F_pc, 32'h0000_3000);
    check_val("rst_dvalid", {31'h0, D_valid}, 32'h0);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, m_fpc + 32'd4);
    check_val("seq_fpc", F_pc, 32'h0000_300C);
    check_val("seq_dpc", D_pc, 32'h0000_3008);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, m_fpc + 32'd4);
    check_val("stall_cnt3", stall_cnt, 32'd3);
    check_val("stall_fcnt", fetch_cnt, 32'd3);
    step(1'b0, 1'b0, 1'b0, m_fpc + 32'd4);
    check_val("release_fpc", F_pc, 32'h0000_3010);

    step(1'b0, 1'b0, 1'b0, 32'h0000_4000);
    check_val("jump_fpc", F_pc, 32'h0000_4000);
    check_val("jump_dpc", D_pc, 32'h0000_3010);

    step(1'b0, 1'b0, 1'b0, 32'h0000_3002);
    check_val("misalign_finstr", F_instr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_7000);
    check_val("misalign_dfault", {31'h0, D_fault}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_6FFC);
    check_val("range_dfault", {31'h0, D_fault}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_2FFC);
    check_val("top_word_dfault", {31'h0, D_fault}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3018);
    step(1'b0, 1'b0, 1'b0, 32'h0000_301C);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3020);

    step(1'b0, 1'b1, 1'b1, 32'h0000_3024);
    check_val("sf_fpc", F_pc, 32'h0000_3020);
    check_val("sf_dinstr", D_instr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3024);
    check_val("sf_reload_dpc", D_pc, 32'h0000_3020);

    for (int i = 0; i < 24; i++) begin
      rpc = 32'h0000_3000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 7) == 0) rpc = rpc + 32'd1;
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rpc);
    end

    step(1'b0, 1'b0, 1'b0, 32'h0000_3040);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3044);
    force dut.fetch_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_r;
    m_fcnt = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 32'h0000_3048);
    check_val("fcnt_wrap", fetch_cnt, 32'h0);

    step(1'b0, 1'b1, 1'b0, 32'h0000_3050);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3050);
    check_val("midrst_fpc", F_pc, 32'h0000_3000);
    check_val("midrst_scnt", stall_cnt, 32'h0);
    check_val("midrst_dpc", D_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
